// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, multi-cycle
// branch flushes, data-memory freeze with timeout, and saturating event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT  = 64,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [4:0]       IF_ID_rs1,
   input  logic [4:0]       IF_ID_rs2,
   input  logic [4:0]       ID_EX_rd,
   input  logic             ID_EX_memread,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             en_if_id,
   output logic             en_id_ex,
   output logic             en_ex_mem,
   output logic             en_mem_wb,
   output logic             hazard,
   output logic             flush_if_id,
   output logic             bubble_id_ex,
   output logic [1:0]       state_o,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StFlush   = 2'd1,
      StMemWait = 2'd2
   } state_e;

   localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       flush_rem_q, flush_rem_d;
   logic [9:0]       wait_q, wait_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use, freeze, stall_inc, flush_inc;
   logic pc_en_c, en_c, hazard_c, flush_c, bubble_c;

   assign load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                     ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
   assign freeze   = dmem_req && !dmem_ready;

   always_comb begin
      pc_en_c     = 1'b1;
      en_c        = 1'b1;
      hazard_c    = 1'b0;
      flush_c     = 1'b0;
      bubble_c    = 1'b0;
      state_d     = state_q;
      flush_rem_d = flush_rem_q;
      wait_d      = 10'd0;
      mem_err_d   = mem_err_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (freeze) begin
         pc_en_c   = 1'b0;
         en_c      = 1'b0;
         hazard_c  = 1'b1;
         stall_inc = 1'b1;
         // This cycle is the MEM_TIMEOUT-th consecutive wait: give up and flag it.
         if ((32'(wait_q) + 32'd1) >= MEM_TIMEOUT) begin
            mem_err_d   = 1'b1;
            state_d     = StRun;
            flush_rem_d = 4'd0;
         end else begin
            state_d = StMemWait;
            wait_d  = wait_q + 10'd1;
         end
      end else begin
         case (state_q)
            StFlush: begin
               flush_c  = 1'b1;
               bubble_c = 1'b1;
               if (branch_taken) begin
                  flush_inc   = 1'b1;
                  flush_rem_d = FlushReload;
               end else begin
                  flush_rem_d = flush_rem_q - 4'd1;
               end
               state_d = (flush_rem_d != 4'd0) ? StFlush : StRun;
            end
            default: begin
               // RUN, and the release cycle of MEM_WAIT, which resumes a pending flush.
               if (branch_taken) begin
                  flush_c     = 1'b1;
                  bubble_c    = 1'b1;
                  flush_inc   = 1'b1;
                  flush_rem_d = FlushReload;
                  state_d     = (FlushReload != 4'd0) ? StFlush : StRun;
               end else begin
                  if (load_use) begin
                     hazard_c  = 1'b1;
                     pc_en_c   = 1'b0;
                     bubble_c  = 1'b1;
                     stall_inc = 1'b1;
                  end
                  state_d = (flush_rem_q != 4'd0) ? StFlush : StRun;
               end
            end
         endcase
      end

      stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= StRun;
         flush_rem_q <= 4'd0;
         wait_q      <= 10'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_rem_q <= flush_rem_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Mealy controls are forced low while reset is held.
   assign pc_en        = pc_en_c & arst_n;
   assign en_if_id     = en_c & arst_n;
   assign en_id_ex     = en_c & arst_n;
   assign en_ex_mem    = en_c & arst_n;
   assign en_mem_wb    = en_c & arst_n;
   assign hazard       = hazard_c & arst_n;
   assign flush_if_id  = flush_c & arst_n;
   assign bubble_id_ex = bubble_c & arst_n;

   assign state_o   = state_q;
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Produces the per-stage enable, hazard, flush and bubble controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Detects load-use hazards, sequences multi-cycle branch/jump flushes, and freezes the whole pipe while a data-memory access waits on its handshake.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_if_id stays asserted after a taken branch/jump (1..15).
- MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before mem_err is flagged (2..1023).
- CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  pipeline clock
- arst_n  in  1  asynchronous active-low reset
- IF_ID_rs1  in  5  rs1 field of the instruction in ID
- IF_ID_rs2  in  5  rs2 field of the instruction in ID
- ID_EX_rd  in  5  destination register of the instruction in EX
- ID_EX_memread  in  1  instruction in EX is a load
- branch_taken  in  1  EX resolved a taken branch or jump this cycle
- dmem_req  in  1  MEM stage access in progress
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register update enable
- en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  pipeline register enables
- hazard  out  1  hold IF/ID contents
- flush_if_id  out  1  zero the IF/ID instruction and PC
- bubble_id_ex  out  1  force ID/EX control fields to 0
- state_o  out  2  current state: 0 RUN, 1 FLUSH, 2 MEM_WAIT
- mem_err  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush events

Behaviour:
- Reset (arst_n=0, takes effect immediately):
  - state RUN; all enables 0; hazard, flush_if_id, bubble_id_ex 0.
  - mem_err 0; both counters 0; flush counter 0; wait counter 0.
- Enables, hazard, flush and bubble are Mealy outputs: a combinational function of the state and current inputs. State and counters are registered.
- Freeze (highest priority, any state): when dmem_req=1 and dmem_ready=0:
  - All en_* and pc_en are 0; hazard=1; flush_if_id=0; bubble_id_ex=0.
  - Next state is MEM_WAIT. The remaining flush count is kept. stall_cnt increments.
- MEM_WAIT, per cycle:
  - The wait counter increments each cycle.
  - On dmem_ready=1, outputs revert that same cycle to the RUN/FLUSH rules. Next state is FLUSH if the remaining flush count is greater than 0, else RUN. The wait counter clears.
  - If the wait counter reaches MEM_TIMEOUT before dmem_ready, mem_err is set (sticky until reset). The freeze releases and next state is RUN.
- RUN, taken branch (second priority): when branch_taken=1:
  - flush_if_id=1, bubble_id_ex=1, pc_en=1, all en_*=1, hazard=0. flush_cnt increments.
  - If FLUSH_CYCLES>1, go to FLUSH with remaining count FLUSH_CYCLES-1; otherwise stay in RUN.
  - The branch wins over a simultaneous load-use hazard.
- RUN, load-use (third priority): ID_EX_memread=1, ID_EX_rd≠0, and ID_EX_rd equals IF_ID_rs1 or IF_ID_rs2:
  - hazard=1, pc_en=0, bubble_id_ex=1; other enables 1. stall_cnt increments. State stays RUN.
- RUN, no event: all enables 1; hazard, flush and bubble 0.
- FLUSH:
  - flush_if_id=1, bubble_id_ex=1, all enables 1; the count decrements.
  - Return to RUN when the count reaches 0.
  - Load-use detection is suppressed in FLUSH, since the ID instruction is being discarded.
  - A new branch_taken in FLUSH reloads the count to FLUSH_CYCLES-1 and increments flush_cnt.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-freeze or mid-flush aborts the sequence immediately to the reset values above.

Test Plan:
- Reset release, idle inputs -> all enables 1; hazard, flush and bubble 0; state_o=0; counters 0.
- ID_EX_memread=1, ID_EX_rd=5, IF_ID_rs2=5 for one cycle -> that cycle hazard=1, pc_en=0, bubble_id_ex=1; stall_cnt=1. With ID_EX_rd=0 instead -> no stall.
- branch_taken pulse with FLUSH_CYCLES=2 -> flush_if_id=1 for exactly 2 cycles; state_o 0→1→0; flush_cnt=1. Branch plus load-use in the same cycle -> flush only, stall_cnt unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready -> all enables 0 for 3 cycles; enables 1 on the ready cycle; stall_cnt=3.
- Freeze entered in FLUSH with 1 flush cycle remaining -> after ready, exactly 1 more flush cycle, then RUN.
- dmem_ready held 0 with MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles; state returns to RUN; mem_err stays 1 until arst_n pulse. With CNT_W=2, 5 stalls -> stall_cnt=3.
